// File: rtl/load_distributor.sv
// load_distributor: dispatches generator pixels to the first free solver slot and
// streams the finished (x, y, iter) results to the VGA writer in round-robin order.
module load_distributor #(
  parameter int NUM_SOLVERS = 4,
  parameter int ITER_W      = 10,
  parameter int FRAME_PIX   = 307200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          draw,
  input  logic                          coord_val,
  input  logic [9:0]                    vga_x,
  input  logic [8:0]                    vga_y,
  input  logic [35:0]                   coord_x,
  input  logic [35:0]                   coord_y,
  output logic                          coord_rdy,
  output logic [NUM_SOLVERS-1:0]        solver_start,
  output logic                          solver_abort,
  output logic [35:0]                   solver_cr,
  output logic [35:0]                   solver_ci,
  input  logic [NUM_SOLVERS-1:0]        solver_done,
  input  logic [NUM_SOLVERS*ITER_W-1:0] solver_iter,
  output logic                          wr_val,
  output logic [9:0]                    wr_x,
  output logic [8:0]                    wr_y,
  output logic [ITER_W-1:0]             wr_iter,
  input  logic                          wr_rdy,
  output logic                          frame_done
);
  localparam int N  = NUM_SOLVERS;
  localparam int SW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, WRITING} slot_t;
  slot_t             st [N];
  logic [9:0]        sx [N];
  logic [8:0]        sy [N];
  logic [ITER_W-1:0] si [N];
  logic [SW-1:0]     rr, wr_slot, acc_idx, sel_idx;
  logic              acc_any, sel_any, xfer, wr_hs, ld;
  logic [18:0]       cnt;
  assign coord_rdy = acc_any;
  assign xfer      = coord_val & acc_any;
  assign wr_hs     = wr_val & wr_rdy;
  assign ld        = !wr_val | wr_rdy;
  // descending scans so the lowest index (or nearest-to-rr slot) wins
  always_comb begin
    acc_any = 1'b0;
    acc_idx = '0;
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (st[SW'(i)] == IDLE) begin
        acc_any = 1'b1;
        acc_idx = SW'(i);
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (st[SW'((int'(rr) + k) % N)] == DONE) begin
        sel_any = 1'b1;
        sel_idx = SW'((int'(rr) + k) % N);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        st[i] <= IDLE;
        sx[i] <= '0;
        sy[i] <= '0;
        si[i] <= '0;
      end
      rr           <= '0;
      wr_slot      <= '0;
      cnt          <= '0;
      solver_start <= '0;
      solver_abort <= 1'b0;
      solver_cr    <= '0;
      solver_ci    <= '0;
      wr_val       <= 1'b0;
      wr_x         <= '0;
      wr_y         <= '0;
      wr_iter      <= '0;
      frame_done   <= 1'b0;
    end else if (draw) begin
      for (int i = 0; i < N; i++) st[i] <= IDLE;
      solver_start <= '0;
      solver_abort <= 1'b1;
      wr_val       <= 1'b0;
      cnt          <= '0;
      frame_done   <= 1'b0;
    end else begin
      solver_start <= '0;
      solver_abort <= 1'b0;
      for (int i = 0; i < N; i++) begin
        if (st[i] == BUSY && solver_done[i]) begin
          st[i] <= DONE;
          si[i] <= solver_iter[i*ITER_W +: ITER_W];
        end
      end
      if (xfer) begin
        st[acc_idx]           <= BUSY;
        sx[acc_idx]           <= vga_x;
        sy[acc_idx]           <= vga_y;
        solver_start[acc_idx] <= 1'b1;
        solver_cr             <= coord_x;
        solver_ci             <= coord_y;
      end
      // the slot leaving the output register is never the one being loaded into it
      if (wr_hs) begin
        st[wr_slot] <= IDLE;
        cnt         <= (cnt == 19'(FRAME_PIX)) ? cnt : cnt + 19'd1;
        frame_done  <= frame_done | (cnt == 19'(FRAME_PIX - 1));
      end
      if (ld) begin
        wr_val <= sel_any;
        if (sel_any) begin
          st[sel_idx] <= WRITING;
          wr_slot     <= sel_idx;
          wr_x        <= sx[sel_idx];
          wr_y        <= sy[sel_idx];
          wr_iter     <= si[sel_idx];
          rr          <= (sel_idx == SW'(N - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_load_distributor.sv
// tb_load_distributor: directed scenarios plus a randomized scoreboard run of a short frame.
module tb_load_distributor;
  localparam int N = 4, IW = 10, FP = 40;
  logic clk = 0, rst_n = 0, draw = 0, coord_val = 0, wr_rdy = 0;
  logic [9:0] vga_x = 0;
  logic [8:0] vga_y = 0;
  logic [35:0] coord_x = 0, coord_y = 0;
  logic coord_rdy, solver_abort, wr_val, frame_done;
  logic [N-1:0] solver_start;
  logic [N-1:0] solver_done = 0;
  logic [35:0] solver_cr, solver_ci;
  logic [N*IW-1:0] solver_iter = 0;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [IW-1:0] wr_iter;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  load_distributor #(.NUM_SOLVERS(N), .ITER_W(IW), .FRAME_PIX(FP)) dut (
    .clk(clk), .rst_n(rst_n), .draw(draw), .coord_val(coord_val),
    .vga_x(vga_x), .vga_y(vga_y), .coord_x(coord_x), .coord_y(coord_y),
    .coord_rdy(coord_rdy), .solver_start(solver_start), .solver_abort(solver_abort),
    .solver_cr(solver_cr), .solver_ci(solver_ci), .solver_done(solver_done),
    .solver_iter(solver_iter), .wr_val(wr_val), .wr_x(wr_x), .wr_y(wr_y),
    .wr_iter(wr_iter), .wr_rdy(wr_rdy), .frame_done(frame_done)
  );

  function automatic logic [IW-1:0] iter_of(int key);
    return IW'(key * 37 + 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; draw = 0; coord_val = 0; wr_rdy = 0; solver_done = '0;
    step(); step();
    checks++;
    if ({solver_start, solver_abort, wr_val, frame_done} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {solver_start, solver_abort, wr_val, frame_done});
    end
    checks++;
    if ({wr_x, wr_y, wr_iter, solver_cr, solver_ci} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {wr_x, wr_y, wr_iter, solver_cr, solver_ci});
    end
    rst_n = 1;
    step();
    checks++;
    if (coord_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", coord_rdy); end
  endtask

  task automatic test_single();
    vga_x = 10'd5; vga_y = 9'd7; coord_x = 36'h1_00000000; coord_y = 36'h0_80000000; coord_val = 1;
    step();
    coord_val = 0;
    checks++;
    if (solver_start !== 4'b0001) begin errors++; $display("FAIL single_start: got %b want 0001", solver_start); end
    checks++;
    if ({solver_cr, solver_ci} !== {36'h1_00000000, 36'h0_80000000}) begin
      errors++; $display("FAIL single_coord: got %h %h want 100000000 080000000", solver_cr, solver_ci);
    end
    step();
    checks++;
    if (solver_start !== 4'b0000) begin errors++; $display("FAIL single_pulse: got %b want 0000", solver_start); end
    solver_iter[0 +: IW] = IW'(42); solver_done = 4'b0001;
    step();
    solver_done = 0;
    checks++;
    if (wr_val !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", wr_val); end
    step();
    checks++;
    if ({wr_val, wr_x, wr_y, wr_iter} !== {1'b1, 10'd5, 9'd7, 10'd42}) begin
      errors++; $display("FAIL single_write: got %b %0d %0d %0d want 1 5 7 42", wr_val, wr_x, wr_y, wr_iter);
    end
    wr_rdy = 1;
    step();
    wr_rdy = 0;
    checks++;
    if (wr_val !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", wr_val); end
  endtask

  task automatic test_fill();
    int n = 0;
    coord_val = 1;
    for (int c = 0; c < 8; c++) begin
      vga_x = 10'(200 + n); vga_y = 9'(n); coord_x = 36'(n);
      if (coord_rdy) begin
        step();
        checks++;
        if (solver_start !== 4'(1 << n)) begin errors++; $display("FAIL fill_start%0d: got %b want %b", n, solver_start, 4'(1 << n)); end
        n++;
      end else step();
    end
    checks++;
    if (n !== 4 || coord_rdy !== 1'b0) begin errors++; $display("FAIL fill_stall: got %0d transfers rdy=%b want 4 rdy=0", n, coord_rdy); end
    solver_iter[2*IW +: IW] = IW'(77); solver_done = 4'b0100;
    step();
    solver_done = 0; wr_rdy = 1;
    step();
    checks++;
    if ({wr_val, wr_x, wr_y, wr_iter} !== {1'b1, 10'd202, 9'd2, 10'd77}) begin
      errors++; $display("FAIL fill_write: got %b %0d %0d %0d want 1 202 2 77", wr_val, wr_x, wr_y, wr_iter);
    end
    for (int c = 0; c < 6 && solver_start == '0; c++) step();
    coord_val = 0; wr_rdy = 0;
    checks++;
    if (solver_start !== 4'b0100 || solver_cr !== 36'd4) begin
      errors++; $display("FAIL fill_reuse: got %b cr=%h want 0100 cr=4", solver_start, solver_cr);
    end
  endtask

  task automatic test_rr();
    int gx[$];
    int gi[$];
    int exp_slot[3] = '{1, 3, 0};
    test_reset();
    for (int k = 0; k < 4; k++) begin
      vga_x = 10'(300 + k); vga_y = 9'(k); coord_val = 1;
      step();
    end
    coord_val = 0; wr_rdy = 1;
    for (int i = 0; i < N; i++) solver_iter[i*IW +: IW] = IW'(50 + i);
    for (int c = 0; c < 12; c++) begin
      solver_done = (c == 0) ? 4'b1010 : (c == 1) ? 4'b0001 : 4'b0000;
      if (wr_val && wr_rdy) begin gx.push_back(int'(wr_x) - 300); gi.push_back(int'(wr_iter)); end
      step();
    end
    solver_done = 0; wr_rdy = 0;
    checks++;
    if (gx.size() !== 3) begin errors++; $display("FAIL rr_count: got %0d writes want 3", gx.size()); end
    for (int i = 0; i < 3 && i < gx.size(); i++) begin
      checks++;
      if (gx[i] !== exp_slot[i] || gi[i] !== 50 + exp_slot[i]) begin
        errors++; $display("FAIL rr_order%0d: got slot %0d iter %0d want slot %0d iter %0d", i, gx[i], gi[i], exp_slot[i], 50 + exp_slot[i]);
      end
    end
  endtask

  task automatic test_stall();
    int gx[$];
    logic [N-1:0] st_seen = '0;
    test_reset();
    for (int k = 0; k < 4; k++) begin
      vga_x = 10'(400 + k); vga_y = 9'(k); coord_val = 1;
      step();
    end
    for (int i = 0; i < N; i++) solver_iter[i*IW +: IW] = IW'(60 + i);
    coord_val = 0; solver_done = 4'b1111;
    step();
    solver_done = 0;
    step();
    vga_x = 10'd500; vga_y = 9'd9; coord_x = 36'h123; coord_val = 1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({wr_val, wr_x, wr_y, wr_iter, coord_rdy, solver_start} !== {1'b1, 10'd400, 9'd0, 10'd60, 1'b0, 4'b0000}) begin
        errors++; $display("FAIL stall_hold%0d: got %b %0d %0d %0d rdy=%b st=%b want 1 400 0 60 rdy=0 st=0000", c, wr_val, wr_x, wr_y, wr_iter, coord_rdy, solver_start);
      end
      step();
    end
    wr_rdy = 1;
    for (int c = 0; c < 12; c++) begin
      if (wr_val && wr_rdy) gx.push_back(int'(wr_x));
      step();
      if (solver_start != '0 && st_seen == '0) begin st_seen = solver_start; coord_val = 0; end
    end
    wr_rdy = 0; coord_val = 0;
    checks++;
    if (gx.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d writes want 4", gx.size()); end
    for (int i = 0; i < 4 && i < gx.size(); i++) begin
      checks++;
      if (gx[i] !== 400 + i) begin errors++; $display("FAIL stall_order%0d: got %0d want %0d", i, gx[i], 400 + i); end
    end
    checks++;
    if (st_seen !== 4'b0001) begin errors++; $display("FAIL stall_resume: got %b want 0001", st_seen); end
  endtask

  task automatic test_draw();
    test_reset();
    for (int k = 0; k < 3; k++) begin
      vga_x = 10'(600 + k); vga_y = 9'(k); coord_val = 1;
      step();
    end
    vga_x = 10'd700; draw = 1;
    step();
    draw = 0; coord_val = 0;
    checks++;
    if ({solver_abort, solver_start, wr_val, frame_done, coord_rdy} !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL draw_pulse: got abort=%b st=%b wv=%b fd=%b rdy=%b want 1 0000 0 0 1", solver_abort, solver_start, wr_val, frame_done, coord_rdy);
    end
    step();
    checks++;
    if ({solver_abort, solver_start} !== 5'b0) begin errors++; $display("FAIL draw_end: got abort=%b st=%b want 0 0000", solver_abort, solver_start); end
    for (int i = 0; i < N; i++) solver_iter[i*IW +: IW] = IW'(90 + i);
    solver_done = 4'b0111; wr_rdy = 1;
    step();
    solver_done = 0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (wr_val !== 1'b0) begin errors++; $display("FAIL draw_late%0d: got wr_val=%b x=%0d want 0", c, wr_val, wr_x); end
      step();
    end
    wr_rdy = 0;
  endtask

  task automatic test_random();
    bit occ[N];
    bit running[N];
    int rem[N];
    int skey[N];
    bit pend[int];
    int key_slot[int];
    int total = FP + 8, sent = 0, writes = 0, seq = 630;
    test_reset();
    for (int c = 0; c < 4000 && writes < total; c++) begin
      bit xfer, hs, stall, any_free;
      int exp_slot, free_slot, key;
      logic [35:0] cx, cy;
      logic [9:0] sx;
      logic [8:0] sy;
      logic [IW-1:0] si;
      coord_val = (sent < total) && ($urandom_range(0, 3) != 0);
      vga_x = 10'(seq % 640); vga_y = 9'((seq / 640) % 480);
      cx = {4'($urandom), $urandom()}; cy = {4'($urandom), $urandom()};
      coord_x = cx; coord_y = cy;
      wr_rdy = ($urandom_range(0, 3) != 0);
      solver_done = '0;
      for (int i = 0; i < N; i++) begin
        if (running[i] && rem[i] == 0) begin
          solver_done[i] = 1; solver_iter[i*IW +: IW] = iter_of(skey[i]); running[i] = 0;
        end else if (running[i]) rem[i]--;
        else if ($urandom_range(0, 15) == 0) begin
          solver_done[i] = 1; solver_iter[i*IW +: IW] = IW'($urandom);
        end
      end
      any_free = 0; exp_slot = -1;
      for (int i = N - 1; i >= 0; i--) if (!occ[i]) begin any_free = 1; exp_slot = i; end
      checks++;
      if (coord_rdy !== any_free) begin errors++; $display("FAIL rand_rdy: got %b want %b", coord_rdy, any_free); end
      xfer = coord_val && coord_rdy;
      hs = wr_val && wr_rdy;
      stall = wr_val && !wr_rdy;
      sx = wr_x; sy = wr_y; si = wr_iter;
      free_slot = -1;
      if (hs) begin
        key = int'(wr_y) * 640 + int'(wr_x);
        checks++;
        if (!pend.exists(key) || wr_iter !== iter_of(key)) begin
          errors++; $display("FAIL rand_write: got x=%0d y=%0d iter=%0d pending=%0d want iter=%0d", wr_x, wr_y, wr_iter, pend.exists(key), iter_of(key));
        end
        if (key_slot.exists(key)) free_slot = key_slot[key];
        pend.delete(key);
        writes++;
      end
      step();
      checks++;
      if (solver_start !== (xfer ? 4'(1 << exp_slot) : 4'b0000)) begin
        errors++; $display("FAIL rand_start: got %b want slot %0d (xfer=%b)", solver_start, exp_slot, xfer);
      end
      if (xfer && exp_slot >= 0) begin
        checks++;
        if ({solver_cr, solver_ci} !== {cx, cy}) begin errors++; $display("FAIL rand_coord: got %h %h want %h %h", solver_cr, solver_ci, cx, cy); end
        occ[exp_slot] = 1; running[exp_slot] = 1; rem[exp_slot] = $urandom_range(0, 5);
        skey[exp_slot] = seq; key_slot[seq] = exp_slot; pend[seq] = 1;
        seq++; sent++;
      end
      if (free_slot >= 0) occ[free_slot] = 0;
      if (stall) begin
        checks++;
        if ({wr_val, wr_x, wr_y, wr_iter} !== {1'b1, sx, sy, si}) begin
          errors++; $display("FAIL rand_hold: got %b %0d %0d %0d want 1 %0d %0d %0d", wr_val, wr_x, wr_y, wr_iter, sx, sy, si);
        end
      end
      checks++;
      if (frame_done !== (writes >= FP)) begin errors++; $display("FAIL rand_frame: got %b want %b after %0d writes", frame_done, writes >= FP, writes); end
    end
    solver_done = '0; coord_val = 0;
    checks++;
    if (writes !== total || pend.num() !== 0) begin errors++; $display("FAIL rand_drain: got %0d writes %0d pending want %0d 0", writes, pend.num(), total); end
    draw = 1;
    step();
    draw = 0; wr_rdy = 0;
    checks++;
    if ({frame_done, solver_abort, wr_val} !== 3'b010) begin
      errors++; $display("FAIL rand_clear: got fd=%b abort=%b wv=%b want 0 1 0", frame_done, solver_abort, wr_val);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    vga_x = 10'd9; vga_y = 9'd3; coord_x = 36'h5; coord_val = 1;
    step(); step();
    coord_val = 0;
    solver_iter[0 +: IW] = IW'(7); solver_done = 4'b0001;
    step();
    solver_done = 0;
    step();
    checks++;
    if (wr_val !== 1'b1) begin errors++; $display("FAIL mid_setup: got %b want 1", wr_val); end
    #3 rst_n = 0;
    #1;
    checks++;
    if ({wr_val, solver_start, solver_abort, frame_done, wr_x, wr_y, wr_iter, solver_cr} !== '0) begin
      errors++; $display("FAIL mid_async: got wv=%b st=%b x=%0d cr=%h want all 0", wr_val, solver_start, wr_x, solver_cr);
    end
    step();
    rst_n = 1;
    step();
    checks++;
    if ({wr_val, solver_start, solver_abort, coord_rdy} !== 7'b0000001) begin
      errors++; $display("FAIL mid_after: got wv=%b st=%b abort=%b rdy=%b want 0 0000 0 1", wr_val, solver_start, solver_abort, coord_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_rr();
    test_stall();
    test_draw();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
